// File: rtl/drone_pkg.sv
// drone_pkg: shared sizing constants and index types for the drone map datapath.
package drone_pkg;
   localparam int LINHAS        = 4;
   localparam int COLUNAS_MAPA  = 16;
   localparam int TEMPO_ESPERA  = 50;
   localparam int DRONE_INICIAL = 1;
   localparam int COL_W         = $clog2(COLUNAS_MAPA);
   localparam int LIN_W         = $clog2(LINHAS);
   localparam int MASK_W        = LINHAS;
   localparam int T_W           = $clog2(TEMPO_ESPERA);
   typedef logic [COL_W-1:0]  coluna_t;
   typedef logic [LIN_W-1:0]  linha_t;
   typedef logic [MASK_W-1:0] mascara_t;
   typedef logic [T_W-1:0]    tempo_t;
endpackage

// File: rtl/rom_mapa.sv
// rom_mapa: column index -> obstacle mask; column 0 is clear, then a single
// obstacle that steps one row per column and wraps around the rows.
module rom_mapa
   import drone_pkg::*;
(
   input  coluna_t  coluna_i,
   output mascara_t mascara_o
);
   always_comb
      mascara_o = (coluna_i == '0) ? '0 : mascara_t'(1) << linha_t'(coluna_i - coluna_t'(1));
endmodule

// File: rtl/fluxo_mapa_drone.sv
// fluxo_mapa_drone: espera timer, map scroll column, button-driven drone row
// and collision lookup against the obstacle ROM.
module fluxo_mapa_drone
   import drone_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               zeraPosicoes,
   input  logic               zeraT,
   input  logic               contaT,
   input  logic               desloca,
   input  logic               botao_cima,
   input  logic               botao_baixo,
   output logic               fim_espera,
   output logic               fim_mapa,
   output logic               colisao,
   output logic [COL_W-1:0]   db_coluna,
   output logic [LIN_W-1:0]   db_linha,
   output logic [MASK_W-1:0]  db_obstaculos
);
   tempo_t   timer_q, timer_d;
   coluna_t  coluna_q, coluna_d;
   linha_t   linha_q, linha_d;
   logic     cima_q, baixo_q, sobe, desce;
   mascara_t mascara;

   rom_mapa u_rom (.coluna_i(coluna_q), .mascara_o(mascara));

   assign fim_espera    = timer_q == tempo_t'(TEMPO_ESPERA-1);
   assign fim_mapa      = coluna_q == coluna_t'(COLUNAS_MAPA-1);
   assign colisao       = mascara[linha_q];
   assign db_coluna     = coluna_q;
   assign db_linha      = linha_q;
   assign db_obstaculos = mascara;
   assign sobe          = botao_cima & ~cima_q;
   assign desce         = botao_baixo & ~baixo_q;

   always_comb begin
      timer_d  = zeraT ? '0 : (contaT && !fim_espera) ? timer_q + tempo_t'(1) : timer_q;
      coluna_d = zeraPosicoes ? '0 : (desloca && !fim_mapa) ? coluna_q + coluna_t'(1) : coluna_q;
      linha_d  = zeraPosicoes ? linha_t'(DRONE_INICIAL)
               : (sobe && !desce && linha_q != linha_t'(LINHAS-1)) ? linha_q + linha_t'(1)
               : (desce && !sobe && linha_q != '0) ? linha_q - linha_t'(1)
               : linha_q;
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         timer_q  <= '0;
         coluna_q <= '0;
         linha_q  <= linha_t'(DRONE_INICIAL);
         cima_q   <= 1'b0;
         baixo_q  <= 1'b0;
      end else begin
         timer_q  <= timer_d;
         coluna_q <= coluna_d;
         linha_q  <= linha_d;
         cima_q   <= botao_cima;
         baixo_q  <= botao_baixo;
      end
endmodule

// File: tb/tb_fluxo_mapa_drone.sv
// tb_fluxo_mapa_drone: directed scenarios plus random traffic against an integer model.
module tb_fluxo_mapa_drone;
   logic       clock = 1'b0, reset = 1'b1;
   logic       zeraPosicoes = 1'b0, zeraT = 1'b0, contaT = 1'b0, desloca = 1'b0;
   logic       botao_cima = 1'b0, botao_baixo = 1'b0;
   logic       fim_espera, fim_mapa, colisao;
   logic [3:0] db_coluna;
   logic [1:0] db_linha;
   logic [3:0] db_obstaculos;

   int n_checks = 0, n_errors = 0;
   int m_t, m_col, m_row, m_pc, m_pb;

   fluxo_mapa_drone dut (
      .clock(clock), .reset(reset), .zeraPosicoes(zeraPosicoes), .zeraT(zeraT),
      .contaT(contaT), .desloca(desloca), .botao_cima(botao_cima), .botao_baixo(botao_baixo),
      .fim_espera(fim_espera), .fim_mapa(fim_mapa), .colisao(colisao),
      .db_coluna(db_coluna), .db_linha(db_linha), .db_obstaculos(db_obstaculos)
   );

   always #5 clock = ~clock;

   function automatic int mask_of(int c);
      return (c == 0) ? 0 : (1 << ((c - 1) % 4));
   endfunction

   function automatic int col_of(int c, int r);
      return (mask_of(c) >> r) & 1;
   endfunction

   task automatic model_reset();
      m_t = 0; m_col = 0; m_row = 1; m_pc = 0; m_pb = 0;
   endtask

   task automatic step();
      int up, dn;
      @(posedge clock);
      up = (botao_cima && !m_pc) ? 1 : 0;
      dn = (botao_baixo && !m_pb) ? 1 : 0;
      m_t = zeraT ? 0 : contaT ? ((m_t + 1 > 49) ? 49 : m_t + 1) : m_t;
      m_col = zeraPosicoes ? 0 : desloca ? ((m_col + 1 > 15) ? 15 : m_col + 1) : m_col;
      if (zeraPosicoes) m_row = 1;
      else if (up && !dn) m_row = (m_row + 1 > 3) ? 3 : m_row + 1;
      else if (dn && !up) m_row = (m_row - 1 < 0) ? 0 : m_row - 1;
      m_pc = int'(botao_cima);
      m_pb = int'(botao_baixo);
      #1;
   endtask

   task automatic clear_inputs();
      zeraPosicoes = 0; zeraT = 0; contaT = 0; desloca = 0; botao_cima = 0; botao_baixo = 0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 0;
      n_checks++;
      if (db_coluna !== 4'd0 || db_linha !== 2'd1 || fim_mapa !== 0 || colisao !== 0 || fim_espera !== 0) begin
         n_errors++;
         $display("FAIL reset_init col=%0d row=%0d fm=%0d col=%0d fe=%0d exp 0 1 0 0 0",
                  db_coluna, db_linha, fim_mapa, colisao, fim_espera);
      end
      contaT = 1; desloca = 1; botao_cima = 1;
      repeat (5) step();
      #2 reset = 1;
      #1;
      model_reset();
      n_checks++;
      if (db_coluna !== 4'd0 || db_linha !== 2'd1 || fim_mapa !== 0 || colisao !== 0 || db_obstaculos !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_async col=%0d row=%0d fm=%0d colisao=%0d mask=%0d exp 0 1 0 0 0",
                  db_coluna, db_linha, fim_mapa, colisao, db_obstaculos);
      end
      #1 reset = 0;
      clear_inputs();
      contaT = 1;
      repeat (48) step();
      n_checks++;
      if (fim_espera !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_timer_cleared fim_espera=%0d exp 0", fim_espera);
      end
      clear_inputs();
   endtask

   task automatic test_timer();
      zeraT = 1; step();
      zeraT = 0; contaT = 1;
      for (int i = 1; i <= 49; i++) begin
         step();
         n_checks++;
         if (fim_espera !== (m_t == 49)) begin
            n_errors++;
            $display("FAIL timer_count i=%0d fim_espera=%0d exp %0d", i, fim_espera, m_t == 49);
         end
      end
      n_checks++;
      if (fim_espera !== 1'b1) begin
         n_errors++;
         $display("FAIL timer_at_49 fim_espera=%0d exp 1", fim_espera);
      end
      repeat (3) step();
      n_checks++;
      if (fim_espera !== 1'b1) begin
         n_errors++;
         $display("FAIL timer_saturate fim_espera=%0d exp 1", fim_espera);
      end
      zeraT = 1; step();
      n_checks++;
      if (fim_espera !== 1'b0) begin
         n_errors++;
         $display("FAIL timer_clear fim_espera=%0d exp 0", fim_espera);
      end
      clear_inputs();
   endtask

   task automatic test_scroll();
      zeraPosicoes = 1; step();
      zeraPosicoes = 0; desloca = 1; step();
      desloca = 0;
      n_checks++;
      if (db_obstaculos !== 4'b0001 || colisao !== 1'b0 || db_coluna !== 4'd1) begin
         n_errors++;
         $display("FAIL scroll_col1 col=%0d mask=%b colisao=%0d exp 1 0001 0", db_coluna, db_obstaculos, colisao);
      end
      desloca = 1; step();
      desloca = 0;
      n_checks++;
      if (db_obstaculos !== 4'b0010 || colisao !== 1'b1 || db_coluna !== 4'd2) begin
         n_errors++;
         $display("FAIL scroll_col2 col=%0d mask=%b colisao=%0d exp 2 0010 1", db_coluna, db_obstaculos, colisao);
      end
   endtask

   task automatic test_movement();
      zeraPosicoes = 1; step(); zeraPosicoes = 0;
      botao_cima = 1; repeat (3) step(); botao_cima = 0; step();
      n_checks++;
      if (db_linha !== 2'd2) begin
         n_errors++;
         $display("FAIL move_held row=%0d exp 2", db_linha);
      end
      repeat (3) begin botao_cima = 1; step(); botao_cima = 0; step(); end
      n_checks++;
      if (db_linha !== 2'd3) begin
         n_errors++;
         $display("FAIL move_up_sat row=%0d exp 3", db_linha);
      end
      botao_cima = 1; botao_baixo = 1; step(); botao_cima = 0; botao_baixo = 0; step();
      n_checks++;
      if (db_linha !== 2'd3) begin
         n_errors++;
         $display("FAIL move_both row=%0d exp 3", db_linha);
      end
      repeat (5) begin botao_baixo = 1; step(); botao_baixo = 0; step(); end
      n_checks++;
      if (db_linha !== 2'd0) begin
         n_errors++;
         $display("FAIL move_down_sat row=%0d exp 0", db_linha);
      end
   endtask

   task automatic test_end_of_map();
      zeraPosicoes = 1; step(); zeraPosicoes = 0;
      desloca = 1;
      for (int i = 1; i <= 15; i++) begin
         step();
         n_checks++;
         if (db_coluna !== 4'(m_col) || colisao !== 1'(col_of(m_col, m_row)) || db_obstaculos !== 4'(mask_of(m_col))) begin
            n_errors++;
            $display("FAIL map_walk col=%0d colisao=%0d mask=%b exp %0d %0d %b",
                     db_coluna, colisao, db_obstaculos, m_col, col_of(m_col, m_row), 4'(mask_of(m_col)));
         end
      end
      n_checks++;
      if (db_coluna !== 4'd15 || fim_mapa !== 1'b1) begin
         n_errors++;
         $display("FAIL map_end col=%0d fim_mapa=%0d exp 15 1", db_coluna, fim_mapa);
      end
      step();
      n_checks++;
      if (db_coluna !== 4'd15 || fim_mapa !== 1'b1) begin
         n_errors++;
         $display("FAIL map_sat col=%0d fim_mapa=%0d exp 15 1", db_coluna, fim_mapa);
      end
      desloca = 0; zeraPosicoes = 1; step(); zeraPosicoes = 0;
      n_checks++;
      if (db_coluna !== 4'd0 || db_linha !== 2'd1 || fim_mapa !== 1'b0) begin
         n_errors++;
         $display("FAIL map_zera col=%0d row=%0d fim_mapa=%0d exp 0 1 0", db_coluna, db_linha, fim_mapa);
      end
   endtask

   task automatic test_priority();
      botao_cima = 1; step(); botao_cima = 0;
      desloca = 1; repeat (3) step(); desloca = 0;
      zeraPosicoes = 1; desloca = 1; botao_cima = 1; step();
      clear_inputs();
      n_checks++;
      if (db_coluna !== 4'd0 || db_linha !== 2'd1) begin
         n_errors++;
         $display("FAIL priority col=%0d row=%0d exp 0 1", db_coluna, db_linha);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         zeraPosicoes = ($urandom_range(0, 19) == 0);
         zeraT        = ($urandom_range(0, 29) == 0);
         contaT       = ($urandom_range(0, 3) != 0);
         desloca      = ($urandom_range(0, 2) == 0);
         botao_cima   = 1'($urandom);
         botao_baixo  = 1'($urandom);
         step();
         n_checks++;
         if (db_coluna !== 4'(m_col) || db_linha !== 2'(m_row) || fim_espera !== (m_t == 49) ||
             fim_mapa !== (m_col == 15) || db_obstaculos !== 4'(mask_of(m_col)) ||
             colisao !== 1'(col_of(m_col, m_row))) begin
            n_errors++;
            $display("FAIL random i=%0d col=%0d row=%0d fe=%0d fm=%0d mask=%b colisao=%0d exp %0d %0d %0d %0d %b %0d",
                     i, db_coluna, db_linha, fim_espera, fim_mapa, db_obstaculos, colisao,
                     m_col, m_row, m_t == 49, m_col == 15, 4'(mask_of(m_col)), col_of(m_col, m_row));
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_timer();
      test_scroll();
      test_movement();
      test_end_of_map();
      test_priority();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
